// File: rtl/bin_to_digits.sv
// Sequential double-dabble binary-to-BCD converter producing eight seven-segment digit codes.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero digit.
module bin_to_digits #(
    parameter int          WIDTH     = 27,
    parameter int unsigned OVF_LIMIT = 99_999_999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [6:0]       d0,
    output logic [6:0]       d1,
    output logic [6:0]       d2,
    output logic [6:0]       d3,
    output logic [6:0]       d4,
    output logic [6:0]       d5,
    output logic [6:0]       d6,
    output logic [6:0]       d7,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_OVF   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] LIMIT = OVF_LIMIT;
    localparam logic [6:0]  DASH  = 7'h50;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [31:0]      r_bcd;
    logic [4:0]       r_cnt;
    logic             r_pend_ovf;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;
    logic [6:0]       r_d [8];

    logic [31:0]      w_bin_ext;
    logic [31:0]      w_bcd_adj;
    logic [6:0]       w_code [8];
    logic             w_accept;
`ifdef LEADING_ZERO_BLANK_EN
    logic             w_seen;
`endif

    assign w_bin_ext = 32'(bin);
    // The done cycle is already IDLE, so a start there must be refused explicitly.
    assign w_accept  = (r_state == S_IDLE) && start && !r_done;

    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < 8; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            else
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        w_seen = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if ((r_bcd[4*i +: 4] != 4'd0) || (i == 0))
                w_seen = 1'b1;
            w_code[i] = w_seen ? {3'b100, r_bcd[4*i +: 4]} : 7'h00;
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 8; i++)
            w_code[i] = {3'b100, r_bcd[4*i +: 4]};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_pend_ovf <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
            for (int i = 0; i < 8; i++)
                r_d[i] <= 7'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift    <= bin;
                        r_bcd      <= '0;
                        r_busy     <= 1'b1;
                        r_pend_ovf <= 1'b0;
                        if (w_bin_ext > LIMIT) begin
                            r_state <= S_OVF;
                        end else begin
                            r_state <= S_SHIFT;
                            r_cnt   <= 5'(WIDTH - 1);
                        end
                    end
                end
                S_SHIFT: begin
                    r_bcd   <= {w_bcd_adj[30:0], r_shift[WIDTH-1]};
                    r_shift <= r_shift << 1;
                    if (r_cnt == 5'd0)
                        r_state <= S_DONE;
                    else
                        r_cnt <= r_cnt - 5'd1;
                end
                S_OVF: begin
                    r_pend_ovf <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ovf   <= r_pend_ovf;
                    for (int i = 0; i < 8; i++)
                        r_d[i] <= r_pend_ovf ? DASH : w_code[i];
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign overflow    = r_ovf;
    assign d0          = r_d[0];
    assign d1          = r_d[1];
    assign d2          = r_d[2];
    assign d3          = r_d[3];
    assign d4          = r_d[4];
    assign d5          = r_d[5];
    assign d6          = r_d[6];
    assign d7          = r_d[7];
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bin_to_digits.sv
// Scoreboard bench for bin_to_digits: arithmetic decimal model, queued expectations, cycle-accurate monitor.
module tb_bin_to_digits;

    localparam int          WIDTH     = 27;
    localparam int unsigned OVF_LIMIT = 99_999_999;
    localparam int          W         = 57;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] bin;
    logic             busy, done, overflow;
    logic [6:0]       d0, d1, d2, d3, d4, d5, d6, d7;
    logic [1:0]       dbg_state;
    logic [55:0]      w_dall;

    bin_to_digits #(.WIDTH(WIDTH), .OVF_LIMIT(OVF_LIMIT)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .overflow(overflow),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
        .o_dbg_state(dbg_state)
    );

    assign w_dall = {d7, d6, d5, d4, d3, d2, d1, d0};

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];
    int           due_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    logic [55:0]  last_d   = '0;
    logic         last_ovf = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits by division, leading-zero rule applied on the value itself.
    function automatic logic [W-1:0] model(input int unsigned v);
        logic [W-1:0] r;
        logic [6:0]   code;
        int unsigned  p;
        int unsigned  dig;
        r = '0;
        if (v > OVF_LIMIT) begin
            r[56] = 1'b1;
            for (int i = 0; i < 8; i++) r[i*7 +: 7] = 7'h50;
        end else begin
            p = 1;
            for (int i = 0; i < 8; i++) begin
                dig  = (v / p) % 10;
                code = {3'b100, 4'(dig)};
`ifdef LEADING_ZERO_BLANK_EN
                if (i > 0 && v < p) code = 7'h00;
`endif
                r[i*7 +: 7] = code;
                p = p * 10;
            end
        end
        return r;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    always begin
        logic [W-1:0] e;
        int           due;
        int           acc;
        logic         exp_busy;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            due_q.delete();
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_done", 64'(done), 64'(0));
            check("rst_ovf", 64'(overflow), 64'(0));
            check("rst_digits", 64'(w_dall), 64'(0));
            check("rst_state", 64'(dbg_state), 64'(0));
        end else begin
            exp_busy = (acc_q.size() > 0) && (cyc >= acc_q[0]) && (cyc < due_q[0]);
            check("busy", 64'(busy), 64'(exp_busy));
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    e   = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    due = due_q.pop_front();
                    check("latency", 64'(cyc - acc), 64'(due - acc));
                    check("result", 64'({overflow, w_dall}), 64'(e));
                end
            end else begin
                check("hold", 64'({overflow, w_dall}), 64'({last_ovf, last_d}));
            end
        end
        last_d   = w_dall;
        last_ovf = overflow;
    end

    task automatic issue(input int unsigned v);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        bin   = WIDTH'(v);
        exp_q.push_back(model(v));
        acc_q.push_back(cyc + 1);
        due_q.push_back(cyc + 1 + ((v > OVF_LIMIT) ? 2 : WIDTH + 1));
        @(negedge clk);
        start = 1'b0;
        bin   = WIDTH'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
            due_q.delete();
        end
    endtask

    initial begin
        int          n;
        int unsigned v;
        rst   = 1'b1;
        start = 1'b1;
        bin   = WIDTH'(12345);
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_digits", 64'(w_dall), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));

        issue(12_345_678); drain();
        issue(0);          drain();
        issue(305);        drain();
        issue(99_999_999); drain();
        issue(100_000_000); drain();

        // Start three cycles into a conversion must be ignored.
        issue(12_345_678);
        repeat (2) @(negedge clk);
        start = 1'b1;
        bin   = WIDTH'(7);
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Start presented during the done cycle must be ignored.
        issue(500);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        bin   = WIDTH'(9);
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Reset in the middle of SHIFT aborts with no done pulse.
        issue(87_654_321);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(42); drain();

        repeat (40) begin
            if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 999);
            else                           v = $urandom_range(0, 134_217_727);
            issue(v);
            drain();
        end
        issue(100_000_001); drain();
        issue(1);           drain();

        repeat (5) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
